// File: rtl/ivs_dma_rd_inf.sv
// ivs_dma_rd_inf: two-port DMA read master; splits each request into INCR bursts at
// MAX_BEATS and 4 KB boundaries. Define IVS_DMA_RD_RESP_CHK_EN to flag rresp errors.
`timescale 1ns/1ps
`ifndef BDWD
`define BDWD 128
`endif

module ivs_dma_rd_inf #(
  parameter int         MAX_BEATS = 16,
  parameter logic [3:0] ARID0     = 4'h0,
  parameter logic [3:0] ARID1     = 4'h1
) (
  input  logic             aclk,
  input  logic             arst,
  input  logic             arready,
  output logic             arvalid,
  output logic [3:0]       arid,
  output logic [31:0]      araddr,
  output logic [5:0]       arlen,
  output logic [2:0]       arsize,
  output logic [1:0]       arburst,
  input  logic             rvalid,
  output logic             rready,
  input  logic [3:0]       rid,
  input  logic [`BDWD-1:0] rdata,
  input  logic [1:0]       rresp,
  input  logic             rlast,
  input  logic             dr0_req,
  input  logic [31:0]      dr0_base,
  input  logic [31:0]      dr0_len,
  output logic             dr0_ack,
  input  logic             dr0_rrdy,
  output logic [`BDWD-1:0] dr0_rdata,
  output logic             dr0_valid,
  output logic             dr0_last,
  output logic             dr0_err,
  input  logic             dr1_req,
  input  logic [31:0]      dr1_base,
  input  logic [31:0]      dr1_len,
  output logic             dr1_ack,
  input  logic             dr1_rrdy,
  output logic [`BDWD-1:0] dr1_rdata,
  output logic             dr1_valid,
  output logic             dr1_last,
  output logic             dr1_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_gnt_q, last_gnt_d;
  logic [31:0] addr_q, addr_d;
  logic [27:0] rem_q, rem_d;
  logic [5:0]  arlen_q, arlen_d;
  logic [3:0]  arid_q;
  logic [6:0]  beats_cur;
  logic [6:0]  beats_nxt;
  logic        last_burst;
  logic        beat_hs;
  logic        unused_bits;

  // Beats of the next burst: bounded by what is left, MAX_BEATS and the 4 KB page end.
  function automatic logic [6:0] burst_len(input logic [31:0] a, input logic [27:0] rem);
    logic [12:0] room;
    logic [27:0] b;
    room = (13'd4096 - {1'b0, a[11:0]}) >> 4;
    b    = rem;
    if (b > 28'(MAX_BEATS)) b = 28'(MAX_BEATS);
    if (b > {15'd0, room})  b = {15'd0, room};
    return b[6:0];
  endfunction

  assign beats_cur  = {1'b0, arlen_q} + 7'd1;
  assign last_burst = (rem_q == {21'd0, beats_cur});
  assign beat_hs    = (state_q == ST_DATA) && rvalid && rready;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (dr0_req || dr1_req) begin
          gnt_d      = (dr0_req && dr1_req) ? ~last_gnt_q : dr1_req;
          last_gnt_d = gnt_d;
          addr_d     = gnt_d ? {dr1_base[31:4], 4'h0} : {dr0_base[31:4], 4'h0};
          rem_d      = gnt_d ? dr1_len[31:4] : dr0_len[31:4];
          state_d    = (rem_d == 28'd0) ? ST_DONE : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (beat_hs && rlast) begin
          rem_d   = rem_q - {21'd0, beats_cur};
          addr_d  = addr_q + {21'd0, beats_cur, 4'h0};
          state_d = (rem_d == 28'd0) ? ST_DONE : ST_ADDR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    beats_nxt = burst_len(addr_d, rem_d);
    arlen_d   = beats_nxt[5:0] - 6'd1;
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      addr_q     <= 32'd0;
      rem_q      <= 28'd0;
      arlen_q    <= 6'd0;
      arid_q     <= 4'h0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      // Burst fields are frozen on entry to ADDR so they hold while arready is low.
      if (state_d == ST_ADDR) begin
        arlen_q <= arlen_d;
        arid_q  <= gnt_d ? ARID1 : ARID0;
      end
    end
  end

  assign arvalid = (state_q == ST_ADDR);
  assign araddr  = addr_q;
  assign arlen   = arlen_q;
  assign arid    = arid_q;
  assign arsize  = 3'b100;
  assign arburst = 2'b01;

  // Read data is a pure pass-through; backpressure goes straight to the bus.
  assign rready    = (state_q == ST_DATA) && (gnt_q ? dr1_rrdy : dr0_rrdy);
  assign dr0_rdata = rdata;
  assign dr1_rdata = rdata;
  assign dr0_valid = (state_q == ST_DATA) && !gnt_q && rvalid;
  assign dr1_valid = (state_q == ST_DATA) && gnt_q && rvalid;
  assign dr0_last  = dr0_valid && rlast && last_burst;
  assign dr1_last  = dr1_valid && rlast && last_burst;
  assign dr0_ack   = (state_q == ST_DONE) && !gnt_q;
  assign dr1_ack   = (state_q == ST_DONE) && gnt_q;

`ifdef IVS_DMA_RD_RESP_CHK_EN
  logic err_q;

  always_ff @(posedge aclk or posedge arst) begin
    if (arst)                            err_q <= 1'b0;
    else if (state_q == ST_IDLE)         err_q <= 1'b0;
    else if (beat_hs && rresp != 2'b00)  err_q <= 1'b1;
  end

  assign dr0_err     = dr0_ack && err_q;
  assign dr1_err     = dr1_ack && err_q;
  assign unused_bits = ^{rid, dr0_base[3:0], dr0_len[3:0], dr1_base[3:0], dr1_len[3:0]};
`else
  assign dr0_err     = 1'b0;
  assign dr1_err     = 1'b0;
  assign unused_bits = ^{rid, rresp, dr0_base[3:0], dr0_len[3:0], dr1_base[3:0], dr1_len[3:0]};
`endif

endmodule
